// File: rtl/uart_sdram_cmd.sv
// uart_sdram_cmd: turns UART byte packets into SDRAM test-port accesses and
// returns either the 16-bit read data (MSB first) or a 'K' write acknowledge
// through the UART transmitter handshake.
//
// Packet format: opcode, A2, A1, A0, then D1, D0 for writes only.
//   opcode 0x57 ('W') = write, 0x52 ('R') = read, anything else is dropped.
// Only one access is in flight at a time. Bytes that arrive while an access
// or a reply is still pending are discarded and flagged in err_ovr.
module uart_sdram_cmd #(
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic              sd_req,
    output logic              sd_we,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [15:0]       sd_wdata,
    input  logic              sd_ack,
    input  logic              sd_rvalid,
    input  logic [15:0]       sd_rdata,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              err_ovr,
    output logic              err_tmo
);

    localparam logic [7:0] OpWrite = 8'h57;
    localparam logic [7:0] OpRead  = 8'h52;
    localparam logic [7:0] AckByte = 8'h4B;
    localparam int unsigned CntW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    typedef enum logic [3:0] {
        StIdle,
        StAddr2,
        StAddr1,
        StAddr0,
        StData1,
        StData0,
        StReq,
        StWaitRd,
        StTxHi,
        StTxLo,
        StTxAck
    } state_e;

    state_e          state_q, state_d;
    logic            rx_done_q;
    logic            we_q, we_d;
    logic [23:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [15:0]     rdata_q, rdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_ovr_q, err_ovr_d;
    logic            err_tmo_q, err_tmo_d;

    logic byte_acc;
    logic in_rx;
    logic busy;
    logic tmo_hit;

    // Byte strobe is the rising edge of rx_done; a long high level counts once.
    assign byte_acc = rx_done & ~rx_done_q;

    assign in_rx = (state_q == StAddr2) || (state_q == StAddr1) || (state_q == StAddr0) ||
                   (state_q == StData1) || (state_q == StData0);

    assign busy = (state_q == StReq) || (state_q == StWaitRd) || (state_q == StTxHi) ||
                  (state_q == StTxLo) || (state_q == StTxAck);

    // An accepted byte in the same cycle beats the timeout.
    assign tmo_hit = in_rx && !byte_acc && (cnt_q == CntMax);

    // Next-state logic: packet assembly, SDRAM handshake, reply sequencing.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_ovr_d = err_ovr_q;
        err_tmo_d = err_tmo_q;

        // Inter-byte timer only runs while a packet is partially received.
        if (in_rx && !byte_acc) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (byte_acc) begin
                    if (rx_data == OpWrite) begin
                        we_d    = 1'b1;
                        state_d = StAddr2;
                    end else if (rx_data == OpRead) begin
                        we_d    = 1'b0;
                        state_d = StAddr2;
                    end
                end
            end
            StAddr2: begin
                if (byte_acc) begin
                    addr_d[23:16] = rx_data;
                    state_d       = StAddr1;
                end
            end
            StAddr1: begin
                if (byte_acc) begin
                    addr_d[15:8] = rx_data;
                    state_d      = StAddr0;
                end
            end
            StAddr0: begin
                if (byte_acc) begin
                    addr_d[7:0] = rx_data;
                    state_d     = we_q ? StData1 : StReq;
                end
            end
            StData1: begin
                if (byte_acc) begin
                    wdata_d[15:8] = rx_data;
                    state_d       = StData0;
                end
            end
            StData0: begin
                if (byte_acc) begin
                    wdata_d[7:0] = rx_data;
                    state_d      = StReq;
                end
            end
            StReq: begin
                if (sd_ack) begin
                    state_d = we_q ? StTxAck : StWaitRd;
                end
            end
            StWaitRd: begin
                if (sd_rvalid) begin
                    rdata_d = sd_rdata;
                    state_d = StTxHi;
                end
            end
            StTxHi: begin
                if (tx_ready) begin
                    state_d = StTxLo;
                end
            end
            StTxLo: begin
                if (tx_ready) begin
                    state_d = StIdle;
                end
            end
            StTxAck: begin
                if (tx_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (tmo_hit) begin
            state_d   = StIdle;
            err_tmo_d = 1'b1;
            cnt_d     = '0;
        end

        if (busy && byte_acc) begin
            err_ovr_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= StIdle;
            rx_done_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            err_ovr_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_done_q <= rx_done;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            err_ovr_q <= err_ovr_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    // Output decode; access fields come straight from registers so they stay
    // stable for the whole request.
    always_comb begin
        sd_req   = (state_q == StReq);
        sd_we    = we_q;
        sd_addr  = ADDR_W'(addr_q);
        sd_wdata = wdata_q;
        tx_valid = (state_q == StTxHi) || (state_q == StTxLo) || (state_q == StTxAck);
        err_ovr  = err_ovr_q;
        err_tmo  = err_tmo_q;
        case (state_q)
            StTxHi:  tx_data = rdata_q[15:8];
            StTxLo:  tx_data = rdata_q[7:0];
            StTxAck: tx_data = AckByte;
            default: tx_data = 8'h00;
        endcase
    end

endmodule
